// File: rtl/mips_mem_pkg.sv
// -----------------------------------------------------------------------------
// mips_mem_pkg
// Shared definitions for the data-memory responder: datapath/address widths,
// wait-counter width, the responder FSM state type, and the address legality
// check used when a request is committed.
// -----------------------------------------------------------------------------
package mips_mem_pkg;

  localparam int DATA_W = 32;
  localparam int ADDR_W = 32;
  localparam int BE_W   = DATA_W / 8;
  localparam int CNT_W  = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } state_t;

  // A request is illegal when it is not word aligned or its word index falls
  // outside the populated memory.
  function automatic logic addr_is_bad(input logic [ADDR_W-1:0] addr,
                                       input int unsigned       depth_words);
    logic [ADDR_W-1:0] word_idx;
    word_idx = {2'b00, addr[ADDR_W-1:2]};
    return (addr[1:0] != 2'b00) || (word_idx >= ADDR_W'(depth_words));
  endfunction

endpackage

// File: rtl/mem_array.sv
// -----------------------------------------------------------------------------
// mem_array
// DEPTH_WORDS x 32-bit storage with byte-enabled synchronous write and
// combinational read.
//
// Ports:
//   clk      - clock; writes happen on its rising edge
//   i_we     - write strobe for the addressed word
//   i_addr   - word index (shared by read and write)
//   i_wdata  - write data
//   i_be     - byte enables; bit i selects bits 8i+7:8i
//   o_rdata  - current contents of the addressed word
// -----------------------------------------------------------------------------
module mem_array
  import mips_mem_pkg::*;
#(
  parameter int DEPTH_WORDS = 256,
  parameter int AW          = 8
) (
  input  logic              clk,
  input  logic              i_we,
  input  logic [AW-1:0]     i_addr,
  input  logic [DATA_W-1:0] i_wdata,
  input  logic [BE_W-1:0]   i_be,
  output logic [DATA_W-1:0] o_rdata
);

  logic [DATA_W-1:0] r_mem [DEPTH_WORDS];
  logic [DATA_W-1:0] w_merged;

  assign o_rdata = r_mem[i_addr];

  // Merge enabled bytes of the new data with the old word so the array is
  // written as a single full word.
  generate
    for (genvar gi = 0; gi < BE_W; gi++) begin : g_byte_merge
      assign w_merged[8*gi +: 8] = i_be[gi] ? i_wdata[8*gi +: 8] : o_rdata[8*gi +: 8];
    end
  endgenerate

  // No reset: memory contents survive a responder reset.
  always_ff @(posedge clk) begin
    if (i_we) begin
      r_mem[i_addr] <= w_merged;
    end
  end

endmodule

// File: rtl/data_mem_responder.sv
// -----------------------------------------------------------------------------
// data_mem_responder
// Single-outstanding data-memory responder for a CPU load/store port. A request
// is accepted in IDLE, waits LATENCY cycles in BUSY, then is committed (store
// written / load data captured) on entry to RESP, where the response is held
// until the CPU accepts it.
//
// Ports:
//   clk        - clock, all state changes on the rising edge
//   rst_n      - synchronous active-low reset
//   req_valid  - CPU request present
//   req_ready  - responder can accept (IDLE only)
//   req_we     - 1 = store, 0 = load
//   req_addr   - byte address
//   req_wdata  - store data
//   req_be     - store byte enables
//   resp_valid - response present (RESP only)
//   resp_ready - CPU accepts the response
//   resp_rdata - load data; 0 for stores and errors
//   resp_err   - misaligned or out-of-range request
// -----------------------------------------------------------------------------
module data_mem_responder
  import mips_mem_pkg::*;
#(
  parameter int DEPTH_WORDS = 256,
  parameter int LATENCY     = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  input  logic [BE_W-1:0]   req_be,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [DATA_W-1:0] resp_rdata,
  output logic              resp_err
);

  localparam int              AW    = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam logic [CNT_W-1:0] LAT_L = CNT_W'(LATENCY);

  state_t            r_state, w_state_next;
  logic [CNT_W-1:0]  r_cnt, w_cnt_next;

  logic              r_we;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_wdata;
  logic [BE_W-1:0]   r_be;

  logic [DATA_W-1:0] r_rdata;
  logic              r_err;

  logic              w_accept;
  logic              w_enter_resp;
  logic              w_cur_we;
  logic [ADDR_W-1:0] w_cur_addr;
  logic [DATA_W-1:0] w_cur_wdata;
  logic [BE_W-1:0]   w_cur_be;
  logic              w_cur_err;
  logic              w_mem_we;
  logic [DATA_W-1:0] w_mem_rdata;

  // ---------------------------------------------------------------------------
  // Next-state and handshake outputs
  // ---------------------------------------------------------------------------
  always_comb begin
    w_state_next = r_state;
    w_cnt_next   = r_cnt;
    w_accept     = 1'b0;
    w_enter_resp = 1'b0;
    req_ready    = 1'b0;
    resp_valid   = 1'b0;
    case (r_state)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          w_accept   = 1'b1;
          w_cnt_next = LAT_L;
          if (LAT_L == '0) begin
            w_state_next = RESP;
            w_enter_resp = 1'b1;
          end else begin
            w_state_next = BUSY;
          end
        end
      end
      BUSY: begin
        w_cnt_next = (r_cnt == '0) ? '0 : r_cnt - 1'b1;
        // <= 1 rather than == 1 so a stray zero count cannot strand the FSM.
        if (r_cnt <= CNT_W'(1)) begin
          w_state_next = RESP;
          w_enter_resp = 1'b1;
        end
      end
      RESP: begin
        resp_valid = 1'b1;
        if (resp_ready) begin
          w_state_next = IDLE;
        end
      end
      default: begin
        w_state_next = IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Commit source: with zero latency the commit happens on the accepting edge,
  // before the request registers are loaded, so the live inputs are used.
  // ---------------------------------------------------------------------------
  always_comb begin
    if (r_state == IDLE) begin
      w_cur_we    = req_we;
      w_cur_addr  = req_addr;
      w_cur_wdata = req_wdata;
      w_cur_be    = req_be;
    end else begin
      w_cur_we    = r_we;
      w_cur_addr  = r_addr;
      w_cur_wdata = r_wdata;
      w_cur_be    = r_be;
    end
  end

  assign w_cur_err = addr_is_bad(w_cur_addr, DEPTH_WORDS);

  // Gated by rst_n so a reset edge that coincides with a commit writes nothing.
  assign w_mem_we = rst_n && w_enter_resp && w_cur_we && !w_cur_err;

  mem_array #(
    .DEPTH_WORDS (DEPTH_WORDS),
    .AW          (AW)
  ) u_mem_array (
    .clk     (clk),
    .i_we    (w_mem_we),
    .i_addr  (w_cur_addr[AW+1:2]),
    .i_wdata (w_cur_wdata),
    .i_be    (w_cur_be),
    .o_rdata (w_mem_rdata)
  );

  // ---------------------------------------------------------------------------
  // State, counter and response registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_rdata <= '0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_cnt   <= w_cnt_next;
      // Only updated on RESP entry, so the response is stable while stalled.
      if (w_enter_resp) begin
        r_err   <= w_cur_err;
        r_rdata <= (w_cur_err || w_cur_we) ? '0 : w_mem_rdata;
      end
    end
  end

  // Request capture needs no reset: it is only consumed after an acceptance.
  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_we    <= req_we;
      r_addr  <= req_addr;
      r_wdata <= req_wdata;
      r_be    <= req_be;
    end
  end

  assign resp_rdata = r_rdata;
  assign resp_err   = r_err;

endmodule

// File: tb/tb_data_mem_responder.sv
// -----------------------------------------------------------------------------
// tb_data_mem_responder
// Directed bench for two builds: LATENCY=2 (instance a) and LATENCY=0 with
// resp_ready tied high (instance b). Both share clock and reset.
// -----------------------------------------------------------------------------
module tb_data_mem_responder;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;

  logic        a_req_valid, a_req_ready, a_req_we;
  logic [31:0] a_req_addr, a_req_wdata;
  logic [3:0]  a_req_be;
  logic        a_resp_valid, a_resp_ready, a_resp_err;
  logic [31:0] a_resp_rdata;

  logic        b_req_valid, b_req_ready, b_req_we;
  logic [31:0] b_req_addr, b_req_wdata;
  logic [3:0]  b_req_be;
  logic        b_resp_valid, b_resp_ready, b_resp_err;
  logic [31:0] b_resp_rdata;

  int n_checks = 0;
  int n_err    = 0;

  data_mem_responder #(.DEPTH_WORDS(256), .LATENCY(2)) u_dut_a (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (a_req_valid),
    .req_ready  (a_req_ready),
    .req_we     (a_req_we),
    .req_addr   (a_req_addr),
    .req_wdata  (a_req_wdata),
    .req_be     (a_req_be),
    .resp_valid (a_resp_valid),
    .resp_ready (a_resp_ready),
    .resp_rdata (a_resp_rdata),
    .resp_err   (a_resp_err)
  );

  data_mem_responder #(.DEPTH_WORDS(256), .LATENCY(0)) u_dut_b (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (b_req_valid),
    .req_ready  (b_req_ready),
    .req_we     (b_req_we),
    .req_addr   (b_req_addr),
    .req_wdata  (b_req_wdata),
    .req_be     (b_req_be),
    .resp_valid (b_resp_valid),
    .resp_ready (b_resp_ready),
    .resp_rdata (b_resp_rdata),
    .resp_err   (b_resp_err)
  );

  // Zero-latency build: stores then back-to-back loads, one per two cycles.
  localparam int          NB = 7;
  localparam logic        B_WE    [NB] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
  localparam logic [31:0] B_ADDR  [NB] = '{32'h0, 32'h4, 32'h8, 32'h8, 32'h0, 32'h4, 32'h6};
  localparam logic [31:0] B_WDATA [NB] = '{32'hA0A0A0A0, 32'hB1B1B1B1, 32'hC2C2C2C2,
                                           32'h0, 32'h0, 32'h0, 32'h0};
  localparam logic [31:0] B_EXP   [NB] = '{32'h0, 32'h0, 32'h0,
                                           32'hC2C2C2C2, 32'hA0A0A0A0, 32'hB1B1B1B1, 32'h0};
  localparam logic        B_ERR   [NB] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  // One full transaction on instance a. During the optional stall the bench
  // drives a conflicting store, which must be ignored.
  task automatic a_xact(input string tag, input logic we, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic [3:0] be,
                        input logic [31:0] exp_rdata, input logic exp_err, input int hold);
    int          lat;
    logic [31:0] got_rdata;
    logic        got_err;
    chk({tag, "/req_ready"}, {31'b0, a_req_ready}, 32'd1);
    a_req_valid = 1'b1;
    a_req_we    = we;
    a_req_addr  = addr;
    a_req_wdata = wdata;
    a_req_be    = be;
    tick();
    a_req_valid = 1'b0;
    lat = 1;
    while (!a_resp_valid && lat < 20) begin
      tick();
      lat++;
    end
    chk({tag, "/latency"}, lat, 32'd3);
    got_rdata = a_resp_rdata;
    got_err   = a_resp_err;
    chk({tag, "/rdata"}, got_rdata, exp_rdata);
    chk({tag, "/err"}, {31'b0, got_err}, {31'b0, exp_err});
    for (int i = 0; i < hold; i++) begin
      a_req_valid = 1'b1;
      a_req_we    = 1'b1;
      a_req_wdata = 32'h0BAD0BAD;
      a_req_be    = 4'hF;
      tick();
      chk({tag, "/hold_valid"}, {31'b0, a_resp_valid}, 32'd1);
      chk({tag, "/hold_rdata"}, a_resp_rdata, exp_rdata);
      chk({tag, "/hold_err"}, {31'b0, a_resp_err}, {31'b0, exp_err});
      chk({tag, "/hold_req_ready"}, {31'b0, a_req_ready}, 32'd0);
    end
    a_req_valid  = 1'b0;
    a_resp_ready = 1'b1;
    tick();
    a_resp_ready = 1'b0;
    chk({tag, "/post_valid"}, {31'b0, a_resp_valid}, 32'd0);
    chk({tag, "/post_req_ready"}, {31'b0, a_req_ready}, 32'd1);
    $display("xact a %s we=%0d addr=0x%08h wdata=0x%08h be=0x%h -> rdata=0x%08h err=%0d lat=%0d",
             tag, we, addr, wdata, be, got_rdata, got_err, lat);
  endtask

  initial begin
    rst_n        = 1'b0;
    a_req_valid  = 1'b0; a_req_we = 1'b0; a_req_addr = '0; a_req_wdata = '0; a_req_be = '0;
    a_resp_ready = 1'b0;
    b_req_valid  = 1'b0; b_req_we = 1'b0; b_req_addr = '0; b_req_wdata = '0; b_req_be = '0;
    b_resp_ready = 1'b1;
    tick();
    tick();
    chk("rst/req_ready", {31'b0, a_req_ready}, 32'd1);
    chk("rst/resp_valid", {31'b0, a_resp_valid}, 32'd0);
    chk("rst/rdata", a_resp_rdata, 32'd0);
    chk("rst/err", {31'b0, a_resp_err}, 32'd0);
    chk("rst_b/req_ready", {31'b0, b_req_ready}, 32'd1);
    rst_n = 1'b1;
    tick();

    // Basic store/load, byte-enable merge, errors and boundaries.
    a_xact("st10",     1'b1, 32'h10,  32'hDEADBEEF, 4'hF, 32'h0,        1'b0, 0);
    a_xact("ld10",     1'b0, 32'h10,  32'h0,        4'h0, 32'hDEADBEEF, 1'b0, 0);
    a_xact("st20",     1'b1, 32'h20,  32'h11223344, 4'hF, 32'h0,        1'b0, 0);
    a_xact("st20_be2", 1'b1, 32'h20,  32'h0000AA00, 4'h2, 32'h0,        1'b0, 0);
    a_xact("ld20",     1'b0, 32'h20,  32'h0,        4'h0, 32'h1122AA44, 1'b0, 0);
    a_xact("ld22_mis", 1'b0, 32'h22,  32'h0,        4'h0, 32'h0,        1'b1, 0);
    a_xact("ld400_oor",1'b0, 32'h400, 32'h0,        4'h0, 32'h0,        1'b1, 0);
    a_xact("ld11_mis", 1'b0, 32'h11,  32'h0,        4'h0, 32'h0,        1'b1, 0);
    a_xact("st22_mis", 1'b1, 32'h22,  32'hFFFFFFFF, 4'hF, 32'h0,        1'b1, 0);
    a_xact("ld20_again",1'b0,32'h20,  32'h0,        4'h0, 32'h1122AA44, 1'b0, 0);
    a_xact("st3fc",    1'b1, 32'h3FC, 32'hCAFEF00D, 4'hF, 32'h0,        1'b0, 0);
    a_xact("ld3fc",    1'b0, 32'h3FC, 32'h0,        4'h0, 32'hCAFEF00D, 1'b0, 0);
    a_xact("st400_oor",1'b1, 32'h400, 32'h12345678, 4'hF, 32'h0,        1'b1, 0);
    a_xact("st10_be0", 1'b1, 32'h10,  32'h12345678, 4'h0, 32'h0,        1'b0, 0);
    a_xact("ld10_hold",1'b0, 32'h10,  32'h0,        4'h0, 32'hDEADBEEF, 1'b0, 5);
    a_xact("ld10_post",1'b0, 32'h10,  32'h0,        4'h0, 32'hDEADBEEF, 1'b0, 0);
    a_xact("st30_zero",1'b1, 32'h30,  32'h0,        4'hF, 32'h0,        1'b0, 0);

    // Reset one cycle after accepting a store: aborted, nothing committed.
    chk("abort/req_ready", {31'b0, a_req_ready}, 32'd1);
    a_req_valid = 1'b1; a_req_we = 1'b1; a_req_addr = 32'h30;
    a_req_wdata = 32'h55; a_req_be = 4'hF;
    tick();
    a_req_valid = 1'b0;
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    chk("abort/idle_req_ready", {31'b0, a_req_ready}, 32'd1);
    chk("abort/resp_valid", {31'b0, a_resp_valid}, 32'd0);
    chk("abort/rdata", a_resp_rdata, 32'd0);
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("abort/no_resp", {31'b0, a_resp_valid}, 32'd0);
    end
    $display("xact a abort we=1 addr=0x00000030 wdata=0x00000055 -> aborted by reset");
    a_xact("ld30",     1'b0, 32'h30,  32'h0,        4'h0, 32'h0,        1'b0, 0);

    // Zero-latency build, resp_ready tied high, request held continuously.
    b_req_valid = 1'b1;
    for (int k = 0; k < NB; k++) begin
      b_req_we    = B_WE[k];
      b_req_addr  = B_ADDR[k];
      b_req_wdata = B_WDATA[k];
      b_req_be    = 4'hF;
      chk("b/req_ready", {31'b0, b_req_ready}, 32'd1);
      tick();
      chk("b/resp_valid", {31'b0, b_resp_valid}, 32'd1);
      chk("b/req_ready_resp", {31'b0, b_req_ready}, 32'd0);
      chk("b/rdata", b_resp_rdata, B_EXP[k]);
      chk("b/err", {31'b0, b_resp_err}, {31'b0, B_ERR[k]});
      $display("xact b %0d we=%0d addr=0x%08h wdata=0x%08h -> rdata=0x%08h err=%0d",
               k, B_WE[k], B_ADDR[k], B_WDATA[k], b_resp_rdata, b_resp_err);
      tick();
      chk("b/post_valid", {31'b0, b_resp_valid}, 32'd0);
    end
    b_req_valid = 1'b0;
    tick();

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

// File: doc/data_mem_responder.md
DATA_MEM_RESPONDER -- requirements
Module: data_mem_responder

Interface
REQ-001 SHALL have parameter DEPTH_WORDS, default 256, meaning number of 32-bit words in the memory array.
REQ-002 SHALL have parameter LATENCY, default 2, meaning wait cycles between request acceptance and response; legal range 0-15.
REQ-003 SHALL have port clk  input  1  the single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, synchronous and active-low.
REQ-005 SHALL have port req_valid  input  1  the CPU presents a request.
REQ-006 SHALL have port req_ready  output  1  the responder can accept a request.
REQ-007 SHALL have port req_we  input  1  1 = store, 0 = load.
REQ-008 SHALL have port req_addr  input  32  byte address.
REQ-009 SHALL have port req_wdata  input  32  store data.
REQ-010 SHALL have port req_be  input  4  byte enables for a store; bit i selects byte i (bits 8i+7:8i).
REQ-011 SHALL have port resp_valid  output  1  a response is presented.
REQ-012 SHALL have port resp_ready  input  1  the CPU accepts the response.
REQ-013 SHALL have port resp_rdata  output  32  load data; 0 for a store or an error.
REQ-014 SHALL have port resp_err  output  1  the request was misaligned or out of range.

Function
REQ-015 SHALL implement the FSM states IDLE, BUSY and RESP.
REQ-016 SHALL drive req_ready = 1 only in IDLE; resp_valid = 1 only in RESP.
REQ-017 SHALL accept a request on an edge where req_valid && req_ready, registering we, addr, wdata and be, and loading the wait counter with LATENCY.
REQ-018 SHALL, from IDLE on acceptance: if LATENCY = 0, go to RESP; otherwise go to BUSY.
REQ-019 SHALL, in BUSY, decrement the counter each cycle and go to RESP on the edge where the counter reaches 1 -> 0.
REQ-020 SHALL, on entry to RESP (the same edge), commit a store and capture load data into resp_rdata.
REQ-021 SHALL make resp_valid high LATENCY+1 cycles after the accepting edge.
REQ-022 SHALL flag an error when addr[1:0] != 0 or addr[31:2] >= DEPTH_WORDS: set resp_err = 1, return rdata = 0, and leave memory unmodified.
REQ-023 SHALL write only the enabled bytes on a store; be = 0 is legal, writes nothing, and returns a normal response.
REQ-024 SHALL hold resp_rdata and resp_err stable while resp_valid && !resp_ready.
REQ-025 SHALL return to IDLE on an edge with resp_valid && resp_ready; req_ready is high in the next cycle, so there is no same-cycle turnaround.
REQ-026 SHALL ignore req_valid in BUSY and RESP, and ignore resp_ready in IDLE and BUSY.
REQ-027 SHALL make a load return the value after all prior committed stores; requests are strictly serialized, one outstanding at most.

Reset
REQ-028 SHALL, when rst_n = 0 at an edge, set state to IDLE, counter to 0, resp_rdata to 0 and resp_err to 0.
REQ-029 SHALL, on reset, leave req_ready = 1 and resp_valid = 0 from the following cycle.
REQ-030 SHALL abort any request in BUSY on reset mid-operation, with no store committed and no response issued.
REQ-031 SHALL NOT clear the memory array on reset.

Structure
REQ-032 SHALL place the state enum, the 32-bit data/address width constants and the 4-bit counter width in shared package mips_mem_pkg.
REQ-033 SHALL use one sub-module, mem_array: DEPTH_WORDS x 32, byte-enabled synchronous write, combinational read.

Verification
REQ-034 SHALL cover this case: LATENCY=2, store addr 0x10, data 0xDEADBEEF, be 0xF, then load 0x10 -> resp_valid 3 cycles after each acceptance; load returns rdata 0xDEADBEEF, err 0.
REQ-035 SHALL cover this case: store be 0x2, data 0x0000AA00 over 0x11223344 at 0x20, then load 0x20 -> rdata 0x1122AA44.
REQ-036 SHALL cover this case: load 0x22 (misaligned) and load 4*DEPTH_WORDS -> err 1, rdata 0; a store to 0x22 leaves memory unchanged on readback.
REQ-037 SHALL cover this case: hold resp_ready = 0 for 5 cycles in RESP -> resp_valid, rdata and err are stable and req_ready stays 0; req_ready = 1 in the cycle after the handshake.
REQ-038 SHALL cover this case: rst_n = 0 one cycle after accepting a store 0x55 to 0x30 (prior value 0x0) -> no response; IDLE next cycle; load 0x30 returns 0x0.
REQ-039 SHALL cover this case: LATENCY=0 build, back-to-back load requests with resp_ready tied high -> resp_valid one cycle after each acceptance, one transaction every 2 cycles.
